// File: rtl/rgb_gauss3x3_scan.sv
// rgb_gauss3x3_scan: scans an RGB frame buffer, converts each pixel to gray, applies a 3x3
// Gaussian kernel [1 2 1; 2 4 2; 1 2 1] / 16 and streams one result per pixel location.
// Border pixels are forced to 0.
// Optional build macro FILTER_THRESHOLD_EN: binarize the result against THRESH (255 / 0).
// Pipeline: address -> RAM data (1) -> window/kernel sum register (1) -> output register (1).
module rgb_gauss3x3_scan #(
    parameter int unsigned IMG_W     = 64,
    parameter int unsigned IMG_H     = 64,
    parameter int unsigned ADD_WIDTH = 12,
    parameter int unsigned THRESH    = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADD_WIDTH-1:0] address_read,
    input  logic [7:0]           data_r_R,
    input  logic [7:0]           data_r_G,
    input  logic [7:0]           data_r_B,
    output logic [ADD_WIDTH-1:0] addr_out,
    output logic [7:0]           data_out,
    output logic                 we_out
);

    localparam int unsigned N  = IMG_W * IMG_H;
    // Step counter runs past N-1 through the drain and pipeline flush.
    localparam int unsigned SW = ADD_WIDTH + 2;
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
`ifdef FILTER_THRESHOLD_EN
    localparam bit ThrEn = 1'b1;
`else
    localparam bit ThrEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  s_q, s_d;
    logic           step_v, step_real;

    // Stage 1: RAM data cycle
    logic           v1_q, real1_q;
    logic [SW-1:0]  s1_q;
    logic [9:0]     pix_sum;
    logic [7:0]     gray, lb_top, lb_mid;
    logic [23:0]    w1_q, w2_q;
    logic [11:0]    ksum;
    logic           center_v;
    logic [7:0]     lb0 [IMG_W];
    logic [7:0]     lb1 [IMG_W];
    logic [CW-1:0]  lb_col_q;
    logic [ADD_WIDTH-1:0] ck_q, cc_q, cr_q;

    // Stage 2: kernel sum register
    logic           v2_q, border2_q;
    logic [11:0]    sum2_q;
    logic [ADD_WIDTH-1:0] k2_q;
    logic [7:0]     filt, pix_val;

    function automatic logic [9:0] col_sum(input logic [23:0] col);
        return {2'b0, col[23:16]} + {1'b0, col[15:8], 1'b0} + {2'b0, col[7:0]};
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
        end
    end

    // FSM next state and step counter
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    s_d     = '0;
                end
            end
            StScan: begin
                s_d = s_q + 1'b1;
                if (s_q == SW'(N - 1)) state_d = StDrain;
            end
            StDrain: begin
                s_d = s_q + 1'b1;
                // Stay until the last write has left the pipeline.
                if (s_q == SW'(N + IMG_W + 3)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        address_read = '0;
        step_v       = 1'b0;
        step_real    = 1'b0;
        unique case (state_q)
            StScan: begin
                busy         = 1'b1;
                address_read = s_q[ADD_WIDTH-1:0];
                step_v       = 1'b1;
                step_real    = 1'b1;
            end
            StDrain: begin
                busy         = 1'b1;
                address_read = ADD_WIDTH'(N - 1);
                step_v       = (s_q <= SW'(N + IMG_W));
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    // Track which step the arriving RAM data belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            real1_q <= 1'b0;
            s1_q    <= '0;
        end else begin
            v1_q    <= step_v;
            real1_q <= step_real;
            s1_q    <= s_q;
        end
    end

    // Gray conversion, window column assembly and kernel sum
    always_comb begin
        pix_sum  = {2'b0, data_r_R} + {1'b0, data_r_G, 1'b0} + {2'b0, data_r_B};
        gray     = real1_q ? 8'(pix_sum >> 2) : 8'd0;
        lb_top   = lb1[lb_col_q];
        lb_mid   = lb0[lb_col_q];
        ksum     = {2'b0, col_sum(w2_q)} + {1'b0, col_sum(w1_q), 1'b0}
                 + {2'b0, col_sum({lb_top, lb_mid, gray})};
        center_v = v1_q && (s1_q >= SW'(IMG_W + 1));
    end

    // Line buffers and window columns; contents survive reset
    always_ff @(posedge clk) begin
        if (v1_q) begin
            lb0[lb_col_q] <= gray;
            lb1[lb_col_q] <= lb_mid;
            w1_q          <= {lb_top, lb_mid, gray};
            w2_q          <= w1_q;
        end
    end

    // Line buffer column pointer and center coordinate counters
    always_ff @(posedge clk) begin
        if (rst || state_q == StIdle) begin
            lb_col_q <= '0;
            ck_q     <= '0;
            cc_q     <= '0;
            cr_q     <= '0;
        end else if (v1_q) begin
            lb_col_q <= (lb_col_q == CW'(IMG_W - 1)) ? '0 : lb_col_q + 1'b1;
            if (center_v) begin
                ck_q <= ck_q + 1'b1;
                if (cc_q == ADD_WIDTH'(IMG_W - 1)) begin
                    cc_q <= '0;
                    cr_q <= cr_q + 1'b1;
                end else begin
                    cc_q <= cc_q + 1'b1;
                end
            end
        end
    end

    // Kernel sum register
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q      <= 1'b0;
            sum2_q    <= '0;
            k2_q      <= '0;
            border2_q <= 1'b0;
        end else begin
            v2_q <= center_v;
            if (center_v) begin
                sum2_q    <= ksum;
                k2_q      <= ck_q;
                border2_q <= (cr_q == '0) || (cr_q == ADD_WIDTH'(IMG_H - 1)) ||
                             (cc_q == '0) || (cc_q == ADD_WIDTH'(IMG_W - 1));
            end
        end
    end

    // Normalize, optional binarization, border suppression
    always_comb begin
        filt    = 8'(sum2_q >> 4);
        pix_val = filt;
        if (ThrEn) pix_val = ({24'b0, filt} >= THRESH) ? 8'd255 : 8'd0;
        if (border2_q) pix_val = 8'd0;
    end

    // Output write stream; address and data hold between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            we_out   <= 1'b0;
            addr_out <= '0;
            data_out <= '0;
        end else begin
            we_out <= v2_q;
            if (v2_q) begin
                addr_out <= k2_q;
                data_out <= pix_val;
            end
        end
    end

endmodule
